// File: rtl/nmux_rr_arbiter_if.sv
// Handshake bundle for the K-channel arbitrated mux: K requesters in, one registered word out.
// Valid/ready: a word moves on a channel only in a cycle where both valid and ready are high.
interface nmux_rr_arbiter_if #(
  parameter int N  = 32,
  parameter int K  = 4,
  parameter int SW = $clog2(K)
);
  logic [K*N-1:0] in_data;
  logic [K-1:0]   in_valid;
  logic [K-1:0]   in_ready;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sel;
  logic           flush;

  modport master (
    output in_data, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/nmux_rr_arbiter.sv
// K-channel arbitrated mux with a single registered output word.
// Round-robin (MODE=0) or fixed lowest-index priority (MODE=1); flush drops the held word.
module nmux_rr_arbiter #(
  parameter int  N    = 32,
  parameter int  K    = 4,
  parameter int  MODE = 0,
  localparam int SW   = $clog2(K)
) (
  input  logic             clk,
  input  logic             rst_n,
  nmux_rr_arbiter_if.slave io_bus,
  output logic [SW-1:0]    o_dbg_ptr
);

  logic [N-1:0]  r_out_data;
  logic          r_out_valid;
  logic [SW-1:0] r_out_sel;
  logic [SW-1:0] r_ptr;

  logic          w_take;
  logic          w_open;
  logic          w_en;
  logic          w_found;
  logic [SW-1:0] w_gidx;
  logic          w_xfer;
  logic [SW-1:0] w_ptr_nxt;
  logic [K-1:0]  w_in_ready;

  assign w_take = r_out_valid & io_bus.out_ready;
  assign w_open = !r_out_valid | w_take;
  assign w_en   = rst_n & w_open & !io_bus.flush;

  // Scan starts at the pointer (or at 0 for fixed priority) and wraps modulo K.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int j = 0; j < K; j++) begin
      if (MODE == 1) idx = j;
      else           idx = (int'(r_ptr) + j) % K;
      if (!w_found && io_bus.in_valid[idx]) begin
        w_found = 1'b1;
        w_gidx  = SW'(idx);
      end
    end
  end

  assign w_xfer    = w_en & w_found;
  assign w_ptr_nxt = (w_gidx == SW'(K - 1)) ? '0 : w_gidx + SW'(1);

  always_comb begin
    w_in_ready = '0;
    if (w_xfer) w_in_ready[w_gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (io_bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_data  <= io_bus.in_data[int'(w_gidx)*N +: N];
      r_out_sel   <= w_gidx;
      r_out_valid <= 1'b1;
      if (MODE == 0) r_ptr <= w_ptr_nxt;
    end else if (w_take) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_sel   = r_out_sel;
  assign o_dbg_ptr        = r_ptr;

endmodule

// File: tb/tb_nmux_rr_arbiter.sv
// Directed bench for nmux_rr_arbiter: round-robin K=4, fixed priority K=4, round-robin K=3.
// Expected {sel,data} words are queued when a grant is driven and popped after the capturing edge.
module tb_nmux_rr_arbiter;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nmux_rr_arbiter_if #(.N(N), .K(4)) b4 ();
  nmux_rr_arbiter_if #(.N(N), .K(4)) bp ();
  nmux_rr_arbiter_if #(.N(N), .K(3)) b3 ();

  logic [1:0] ptr4, ptrp, ptr3;

  nmux_rr_arbiter #(.N(N), .K(4), .MODE(0)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .io_bus(b4.slave), .o_dbg_ptr(ptr4));
  nmux_rr_arbiter #(.N(N), .K(4), .MODE(1)) u_fp4 (
    .clk(clk), .rst_n(rst_n), .io_bus(bp.slave), .o_dbg_ptr(ptrp));
  nmux_rr_arbiter #(.N(N), .K(3), .MODE(0)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .io_bus(b3.slave), .o_dbg_ptr(ptr3));

  int n_pass  = 0;
  int n_total = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [1:0] sel, input logic [7:0] data);
    exp_q.push_back({sel, data});
  endtask

  task automatic sb_pop(input string tag, input logic [1:0] sel, input logic [7:0] data,
                        input logic valid);
    logic [9:0] e;
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'({sel, data}), 32'(e));
    end
  endtask

  initial begin
    logic [3:0] oh4;
    logic [2:0] oh3;
    int g;

    rst_n = 1'b0;
    b4.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bp.in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    b3.in_data = {8'hC2, 8'hC1, 8'hC0};
    b4.in_valid = 4'hF;  bp.in_valid = 4'hF;  b3.in_valid = 3'h7;
    b4.out_ready = 1'b1; bp.out_ready = 1'b1; b3.out_ready = 1'b1;
    b4.flush = 1'b0;     bp.flush = 1'b0;     b3.flush = 1'b0;

    // Reset held two cycles with every requester valid.
    for (int c = 0; c < 2; c++) begin
      cyc();
      chk("rst_in_ready", 32'(b4.in_ready), 32'h0);
      chk("rst_in_ready_k3", 32'(b3.in_ready), 32'h0);
      chk("rst_out_valid", 32'(b4.out_valid), 32'h0);
      chk("rst_out_data", 32'(b4.out_data), 32'h0);
      chk("rst_out_sel", 32'(b4.out_sel), 32'h0);
    end
    chk("rst_ptr", 32'(ptr4), 32'h0);

    rst_n = 1'b1;
    bp.in_valid = 4'h0;
    b3.in_valid = 3'h0;
    #1;

    // Rotation: 0,1,2,3,0,1 on consecutive cycles.
    for (int i = 0; i < 6; i++) begin
      g = i % 4;
      oh4 = 4'b0001 << g;
      chk("rr_grant", 32'(b4.in_ready), 32'(oh4));
      sb_push(2'(g), 8'hA0 + 8'(g));
      cyc();
      sb_pop("rr_out", b4.out_sel, b4.out_data, b4.out_valid);
    end

    // Back-pressure while holding A1.
    b4.out_ready = 1'b0;
    #1;
    chk("bp_in_ready", 32'(b4.in_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("bp_hold_data", 32'(b4.out_data), 32'hA1);
      chk("bp_hold_valid", 32'(b4.out_valid), 32'h1);
      chk("bp_hold_sel", 32'(b4.out_sel), 32'h1);
      chk("bp_hold_ready", 32'(b4.in_ready), 32'h0);
    end
    b4.out_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(b4.in_ready), 32'b0100);
    sb_push(2'd2, 8'hA2);
    cyc();
    sb_pop("bp_release_out", b4.out_sel, b4.out_data, b4.out_valid);

    // Take with nothing new: valid drops, data kept.
    b4.in_valid = 4'h0;
    cyc();
    chk("drain_valid", 32'(b4.out_valid), 32'h0);
    chk("drain_data_kept", 32'(b4.out_data), 32'hA2);

    // Flush while holding 0x55.
    b4.in_data[7:0] = 8'h55;
    b4.in_valid = 4'b0001;
    #1;
    chk("fl_pre_grant", 32'(b4.in_ready), 32'b0001);
    sb_push(2'd0, 8'h55);
    cyc();
    sb_pop("fl_capture", b4.out_sel, b4.out_data, b4.out_valid);
    chk("fl_ptr_before", 32'(ptr4), 32'h1);
    b4.flush = 1'b1;
    b4.out_ready = 1'b0;
    #1;
    chk("fl_in_ready", 32'(b4.in_ready), 32'h0);
    cyc();
    b4.flush = 1'b0;
    #1;
    chk("fl_out_valid", 32'(b4.out_valid), 32'h0);
    chk("fl_ptr_after", 32'(ptr4), 32'h1);
    chk("fl_next_grant", 32'(b4.in_ready), 32'b0001);
    sb_push(2'd0, 8'h55);
    cyc();
    sb_pop("fl_regrant", b4.out_sel, b4.out_data, b4.out_valid);
    b4.in_valid = 4'h0;
    b4.out_ready = 1'b1;

    // Fixed priority: ch1 beats ch3, then ch3 alone.
    bp.in_valid = 4'b1010;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("fp_grant_ch1", 32'(bp.in_ready), 32'b0010);
      sb_push(2'd1, 8'hD1);
      cyc();
      sb_pop("fp_out_ch1", bp.out_sel, bp.out_data, bp.out_valid);
    end
    bp.in_valid = 4'b1000;
    #1;
    chk("fp_grant_ch3", 32'(bp.in_ready), 32'b1000);
    sb_push(2'd3, 8'hD3);
    cyc();
    sb_pop("fp_out_ch3", bp.out_sel, bp.out_data, bp.out_valid);
    bp.in_valid = 4'h0;

    // K=3 wrap: ch2 first, pointer must wrap to 0.
    b3.in_valid = 3'b100;
    #1;
    chk("k3_grant_ch2", 32'(b3.in_ready), 32'b100);
    sb_push(2'd2, 8'hC2);
    cyc();
    sb_pop("k3_out_ch2", b3.out_sel, b3.out_data, b3.out_valid);
    chk("k3_ptr_wrap", 32'(ptr3), 32'h0);
    b3.in_valid = 3'b111;
    #1;
    g = 0;
    for (int i = 0; i < 5; i++) begin
      oh3 = 3'b001 << g;
      chk("k3_grant", 32'(b3.in_ready), 32'(oh3));
      sb_push(2'(g), 8'hC0 + 8'(g));
      cyc();
      sb_pop("k3_out", b3.out_sel, b3.out_data, b3.out_valid);
      chk("k3_ptr", 32'(ptr3), 32'((g + 1) % 3));
      g = (g + 1) % 3;
    end
    b3.in_valid = 3'b000;

    chk("sb_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
